split_router_two: RTL and testbench
===================================

// Module: split_router_two
// PURPOSE
//  One-to-two packet splitter: the synchronous counterpart of the two-input arbiter/merge.
//  Accepts one packet stream and steers each packet to output 0 or 1 using a destination bit in the packet.
//  Each output has its own FIFO, so a stalled output does not block packets bound for the other output.
//  Sits on the fan-out side of the NoC router, between the link receiver and the per-port consumers.
// PARAMETERS
//  WIDTH     33  packet width in bits, including the routing fields
//  DEST_BIT  32  bit index of the destination bit: 0 -> out0, 1 -> out1
//  BCAST_BIT 31  bit index of the broadcast flag; used only when SPLIT_BCAST_EN is defined
//  DEPTH     2   entries per output FIFO; power of two, >= 2
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_data    in   WIDTH  input packet
//  in_valid   in   1      in_data is valid
//  in_ready   out  1      the block accepts in_data this cycle
//  out0_data  out  WIDTH  head of FIFO 0
//  out0_valid out  1      FIFO 0 is not empty
//  out0_ready in   1      consumer 0 takes out0_data
//  out1_data  out  WIDTH  head of FIFO 1
//  out1_valid out  1      FIFO 1 is not empty
//  out1_ready in   1      consumer 1 takes out1_data
// BEHAVIOUR
//  - Transfer rule: a transfer occurs on a rising edge where valid && ready.
//  - Valid/data stability: valid and data hold stable until the transfer; no retraction.
//  - Reset (async assert, sync release):
//    - both FIFOs emptied; write/read pointers = 0
//    - out*_valid = 0, out*_data = 0
//    - in_ready = 0 while rst_n = 0
//  - Steering: sel = in_data[DEST_BIT].
//  - in_ready = !full[sel].
//    - Combinational from in_data[DEST_BIT] and the FIFO counts only.
//    - Never depends on out*_ready, so there is no ready-to-ready path.
//  - Full FIFO: input stalls even if the same FIFO is popped that cycle; the packet is accepted the next cycle.
//  - Latency: a packet accepted at edge N is visible on outX_valid/outX_data after edge N; 1 cycle.
//  - Ordering: per-output FIFO order is preserved. No ordering is implied between out0 and out1.
//  - Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
//    - When the FIFO was empty, the pushed entry becomes head after the edge.
//  - Pop on an empty FIFO is impossible because valid = 0.
//  - Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
//    - count is log2(DEPTH)+1 bits, range 0..DEPTH.
//    - full = (count == DEPTH).
//  - Each FIFO is independent. A full FIFO 0 never blocks packets bound for out1.
//  - Packets are forwarded unmodified, including the routing bits.
//  - Reset mid-operation: all buffered packets are discarded. No partial packet is presented after release.
// CONFIGURATION
//  SPLIT_BCAST_EN defined:
//   - A packet with in_data[BCAST_BIT] = 1 is written to both FIFOs in the same cycle, and DEST_BIT is ignored.
//   - in_ready = !full0 && !full1 for broadcast packets.
//   - Both copies are pushed atomically; one copy is never delivered without the other.
//  SPLIT_BCAST_EN undefined:
//   - BCAST_BIT is ignored and treated as payload.
//   - The packet goes only to the output given by DEST_BIT.
// TESTING
//  1 Reset:
//    - drive rst_n = 0 with in_valid = 1 -> in_ready = 0, out0_valid = out1_valid = 0.
//    - release rst_n -> FIFOs empty.
//  2 Steering:
//    - send 33'h1_0000_00AA, then 33'h0_0000_0055, with both outputs ready.
//    - -> out1 receives 33'h1_0000_00AA and out0 receives 33'h0_0000_0055, each 1 cycle after acceptance.
//  3 Back-pressure isolation:
//    - hold out0_ready = 0 and send 3 packets to out0 -> the first 2 are accepted; in_ready = 0 on the 3rd.
//    - then send 33'h1_0000_0001 -> accepted and delivered on out1.
//    - release out0_ready -> out0 delivers its packets in order.
//  4 Full plus pop:
//    - FIFO0 full; assert out0_ready while offering a packet to out0.
//    - -> in_ready = 0 that cycle; the packet is accepted the next cycle; no loss or duplicate.
//  5 Broadcast (SPLIT_BCAST_EN):
//    - send 33'h0_8000_0077 -> both out0 and out1 present 33'h0_8000_0077.
//    - with FIFO1 full -> in_ready = 0 and FIFO0 is unchanged.
//  6 Async reset mid-stream:
//    - drop rst_n with packets buffered in both FIFOs -> outputs go invalid immediately, without waiting for a clock edge.
//    - the first packet after release arrives as if the block were fresh.

Source files
------------

// File: rtl/split_router_two.sv
// One-to-two packet splitter steered by in_data[DEST_BIT], 1-cycle latency, per-output FIFO; in_ready drops only when the target FIFO is full.
// Optional broadcast (in_data[BCAST_BIT] writes both FIFOs atomically) is enabled by defining SPLIT_BCAST_EN.
module split_router_two #(
  parameter int WIDTH     = 33,
  parameter int DEST_BIT  = 32,
  parameter int BCAST_BIT = 31,
  parameter int DEPTH     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [1:0]       full;
  logic [1:0]       vld;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             sel;
  logic             bcast;
  logic             accept;

`ifdef SPLIT_BCAST_EN
  assign bcast = in_data[BCAST_BIT];
`else
  logic bcast_bit_unused;
  assign bcast_bit_unused = in_data[BCAST_BIT];
  assign bcast = 1'b0;
`endif

  assign sel = in_data[DEST_BIT];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      full[p] = (cnt_q[p] == FULL_CNT);
      vld[p]  = (cnt_q[p] != '0);
    end
    // Ready looks only at the FIFO counts, never at the consumers' ready.
    in_ready = rst_n && (bcast ? (full == 2'b00) : !full[sel]);
    accept   = in_valid && in_ready;
    push[0]  = accept && (bcast || !sel);
    push[1]  = accept && (bcast || sel);
    pop[0]   = vld[0] && out0_ready;
    pop[1]   = vld[1] && out1_ready;
    for (int p = 0; p < 2; p++) begin
      wptr_d[p] = push[p] ? wptr_q[p] + PW'(1) : wptr_q[p];
      rptr_d[p] = pop[p]  ? rptr_q[p] + PW'(1) : rptr_q[p];
      case ({push[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + CW'(1);
        2'b01:   cnt_d[p] = cnt_q[p] - CW'(1);
        default: cnt_d[p] = cnt_q[p];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < DEPTH; i++) mem_q[p][i] <= '0;
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
        cnt_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) mem_q[p][wptr_q[p]] <= in_data;
        wptr_q[p] <= wptr_d[p];
        rptr_q[p] <= rptr_d[p];
        cnt_q[p]  <= cnt_d[p];
      end
    end
  end

  assign out0_data  = mem_q[0][rptr_q[0]];
  assign out1_data  = mem_q[1][rptr_q[1]];
  assign out0_valid = vld[0];
  assign out1_valid = vld[1];

endmodule

// File: tb/tb_split_router_two.sv
// Directed bench for split_router_two: reset, steering, isolation, full+pop, broadcast/payload, async reset.
module tb_split_router_two;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [32:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] out0_data;
  logic        out0_valid;
  logic        out0_ready = 1'b0;
  logic [32:0] out1_data;
  logic        out1_valid;
  logic        out1_ready = 1'b0;

  int total = 0;
  int bad = 0;

  split_router_two dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 33'h0_0000_0011;
    step(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL rst_out0_valid got=%b exp=0", out0_valid); end
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL rst_out1_valid got=%b exp=0", out1_valid); end
    total++; if (out0_data !== 33'h0) begin bad++; $display("FAIL rst_out0_data got=%h exp=0", out0_data); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    total++; if ({out0_valid, out1_valid} !== 2'b00) begin bad++; $display("FAIL rel_empty got=%b exp=00", {out0_valid, out1_valid}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_steering();
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_data = 33'h1_0000_00AA;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL steer_rdy1 got=%b exp=1", in_ready); end
    step();
    total++; if (out1_valid !== 1'b1 || out1_data !== 33'h1_0000_00AA) begin bad++; $display("FAIL steer_out1 got=%b/%h exp=1/1000000aa", out1_valid, out1_data); end
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL steer_out0_idle got=%b exp=0", out0_valid); end
    in_data = 33'h0_0000_0055;
    step();
    in_valid = 1'b0;
    total++; if (out0_valid !== 1'b1 || out0_data !== 33'h0_0000_0055) begin bad++; $display("FAIL steer_out0 got=%b/%h exp=1/000000055", out0_valid, out0_data); end
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL steer_out1_drained got=%b exp=0", out1_valid); end
    step();
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL steer_out0_drained got=%b exp=0", out0_valid); end
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_data = 33'h0_0000_0101;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_rdy_a1 got=%b exp=1", in_ready); end
    step();
    in_data = 33'h0_0000_0102;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_rdy_a2 got=%b exp=1", in_ready); end
    step();
    in_data = 33'h0_0000_0103;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_rdy_a3 got=%b exp=0", in_ready); end
    step();
    total++; if (out0_data !== 33'h0_0000_0101) begin bad++; $display("FAIL bp_head got=%h exp=000000101", out0_data); end
    in_data = 33'h1_0000_0001;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_rdy_out1 got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out1_valid !== 1'b1 || out1_data !== 33'h1_0000_0001) begin bad++; $display("FAIL bp_out1 got=%b/%h exp=1/100000001", out1_valid, out1_data); end
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    total++; if (out0_valid !== 1'b1 || out0_data !== 33'h0_0000_0102) begin bad++; $display("FAIL bp_order got=%b/%h exp=1/000000102", out0_valid, out0_data); end
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL bp_out1_drained got=%b exp=0", out1_valid); end
    step();
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL bp_out0_drained got=%b exp=0 (no A3)", out0_valid); end
  endtask

  task automatic test_full_pop();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_data = 33'h0_0000_0B01;
    step();
    in_data = 33'h0_0000_0B02;
    step();
    in_data = 33'h0_0000_0B03; out0_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fp_stall got=%b exp=0", in_ready); end
    step();
    total++; if (out0_data !== 33'h0_0000_0B02) begin bad++; $display("FAIL fp_head2 got=%h exp=000000b02", out0_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fp_resume got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out0_valid !== 1'b1 || out0_data !== 33'h0_0000_0B03) begin bad++; $display("FAIL fp_head3 got=%b/%h exp=1/000000b03", out0_valid, out0_data); end
    step();
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL fp_no_dup got=%b exp=0", out0_valid); end
  endtask

`ifdef SPLIT_BCAST_EN
  task automatic test_broadcast();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_data = 33'h0_8000_0077;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_rdy got=%b exp=1", in_ready); end
    step();
    total++; if (out0_valid !== 1'b1 || out0_data !== 33'h0_8000_0077) begin bad++; $display("FAIL bc_out0 got=%b/%h exp=1/080000077", out0_valid, out0_data); end
    total++; if (out1_valid !== 1'b1 || out1_data !== 33'h0_8000_0077) begin bad++; $display("FAIL bc_out1 got=%b/%h exp=1/080000077", out1_valid, out1_data); end
    in_data = 33'h1_0000_0001;
    step();
    in_data = 33'h0_8000_0078;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_full1_stall got=%b exp=0", in_ready); end
    step();
    in_valid = 1'b0;
    out0_ready = 1'b1;
    step();
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL bc_fifo0_unchanged got=%b exp=0", out0_valid); end
    out1_ready = 1'b1;
    step(); step();
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL bc_fifo1_drained got=%b exp=0", out1_valid); end
  endtask
`else
  task automatic test_broadcast();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_data = 33'h0_8000_0077;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pl_rdy got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    total++; if (out0_valid !== 1'b1 || out0_data !== 33'h0_8000_0077) begin bad++; $display("FAIL pl_out0 got=%b/%h exp=1/080000077", out0_valid, out0_data); end
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL pl_out1_idle got=%b exp=0", out1_valid); end
    out0_ready = 1'b1;
    step();
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL pl_drained got=%b exp=0", out0_valid); end
  endtask
`endif

  task automatic test_async_reset();
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_data = 33'h0_0000_0201;
    step();
    in_data = 33'h1_0000_0202;
    step();
    in_valid = 1'b0;
    total++; if ({out0_valid, out1_valid} !== 2'b11) begin bad++; $display("FAIL ar_loaded got=%b exp=11", {out0_valid, out1_valid}); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({out0_valid, out1_valid} !== 2'b00) begin bad++; $display("FAIL ar_async_valid got=%b exp=00", {out0_valid, out1_valid}); end
    total++; if (out0_data !== 33'h0 || out1_data !== 33'h0) begin bad++; $display("FAIL ar_async_data got=%h/%h exp=0/0", out0_data, out1_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ar_in_ready got=%b exp=0", in_ready); end
    step();
    rst_n = 1'b1;
    step();
    out1_ready = 1'b1;
    in_valid = 1'b1; in_data = 33'h1_0000_0303;
    step();
    in_valid = 1'b0;
    total++; if (out1_valid !== 1'b1 || out1_data !== 33'h1_0000_0303) begin bad++; $display("FAIL ar_fresh_out1 got=%b/%h exp=1/100000303", out1_valid, out1_data); end
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL ar_fresh_out0 got=%b exp=0", out0_valid); end
    step();
    total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL ar_fresh_single got=%b exp=0", out1_valid); end
  endtask

  initial begin
    test_reset();
    test_steering();
    test_backpressure();
    test_full_pop();
    test_broadcast();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
